round_sequencer: RTL and testbench

//  Game-round controller for the 60 s BCD countdown timer. Drives the timer's

---
 rtl/round_sequencer.sv | 158 +++++++++++++++
 tb/tb_round_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Game-round controller for the BCD countdown timer: idle, get-ready countdown, timed play,
// post-round hold, then the next round or game over. All outputs are registered.
module round_sequencer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned READY_SECS = 3,
  parameter int unsigned END_SECS   = 2,
  parameter int unsigned NUM_ROUNDS = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       time_up_i,
  input  logic [7:0] time_left_i,
  output logic       timer_reset_o,
  output logic       playing_o,
  output logic [3:0] ready_count_o,
  output logic [3:0] round_num_o,
  output logic       round_done_o,
  output logic       game_over_o,
  output logic [2:0] state_o,
  output logic [7:0] hud_time_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReady = 3'd1;
  localparam logic [2:0] StPlay  = 3'd2;
  localparam logic [2:0] StEnd   = 3'd3;
  localparam logic [2:0] StOver  = 3'd4;

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned EW = (END_SECS > 1) ? $clog2(END_SECS) : 1;

  logic [2:0]    state_q, state_d;
  logic [3:0]    ready_q, ready_d;
  logic [3:0]    round_q, round_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [EW-1:0] end_cnt_q, end_cnt_d;
  logic          round_done_d;
  logic          start_q;
  logic          start_edge;
  logic          tick;

  assign start_edge = start_i & ~start_q;
  assign tick       = (presc_q == CW'(CLK_HZ - 1));

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    round_d      = round_q;
    end_cnt_d    = end_cnt_q;
    round_done_d = 1'b0;
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      ready_d   = 4'd0;
      round_d   = 4'd0;
      end_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_d = StReady;
            round_d = 4'd1;
            ready_d = 4'(READY_SECS);
          end
        end
        StReady: begin
          if (tick) begin
            if (ready_q == 4'd1) begin
              state_d = StPlay;
              ready_d = 4'd0;
            end else begin
              ready_d = ready_q - 4'd1;
            end
          end
        end
        StPlay: begin
          if (time_up_i) begin
            state_d      = StEnd;
            round_done_d = 1'b1;
            end_cnt_d    = '0;
          end
        end
        StEnd: begin
          if (tick) begin
            if (end_cnt_q == EW'(END_SECS - 1)) begin
              end_cnt_d = '0;
              if (round_q == 4'(NUM_ROUNDS)) begin
                state_d = StOver;
              end else begin
                state_d = StReady;
                round_d = round_q + 4'd1;
                ready_d = 4'(READY_SECS);
              end
            end else begin
              end_cnt_d = end_cnt_q + EW'(1);
            end
          end
        end
        StOver: begin
          if (start_edge) begin
            state_d = StReady;
            round_d = 4'd1;
            ready_d = 4'(READY_SECS);
          end
        end
        default: begin
          state_d   = StIdle;
          ready_d   = 4'd0;
          round_d   = 4'd0;
          end_cnt_d = '0;
        end
      endcase
    end

    // Restart the one-second prescaler on every state change.
    if (state_d != state_q) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      ready_q       <= 4'd0;
      round_q       <= 4'd0;
      presc_q       <= '0;
      end_cnt_q     <= '0;
      start_q       <= 1'b1;
      timer_reset_o <= 1'b1;
      playing_o     <= 1'b0;
      round_done_o  <= 1'b0;
      game_over_o   <= 1'b0;
      hud_time_o    <= 8'h00;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      round_q       <= round_d;
      presc_q       <= presc_d;
      end_cnt_q     <= end_cnt_d;
      start_q       <= start_i;
      timer_reset_o <= (state_d != StPlay);
      playing_o     <= (state_d == StPlay);
      round_done_o  <= round_done_d;
      game_over_o   <= (state_d == StOver);
      hud_time_o    <= ((state_d == StPlay) || (state_d == StEnd)) ? time_left_i : 8'h00;
    end
  end

  assign state_o       = state_q;
  assign ready_count_o = ready_q;
  assign round_num_o   = round_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed vector table, hand-written corner sequences and
// randomized stimulus checked every cycle against a time-in-state reference model.
module tb_round_sequencer;

  localparam int HZ    = 4;
  localparam int RDY   = 3;
  localparam int ENDS  = 2;
  localparam int NR    = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b1;
  logic       abort = 1'b0;
  logic       time_up = 1'b0;
  logic [7:0] time_left = 8'h00;
  logic       timer_reset, playing, round_done, game_over;
  logic [3:0] ready_count, round_num;
  logic [2:0] state;
  logic [7:0] hud_time;

  round_sequencer #(
    .CLK_HZ    (HZ),
    .READY_SECS(RDY),
    .END_SECS  (ENDS),
    .NUM_ROUNDS(NR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start_i      (start),
    .abort_i      (abort),
    .time_up_i    (time_up),
    .time_left_i  (time_left),
    .timer_reset_o(timer_reset),
    .playing_o    (playing),
    .ready_count_o(ready_count),
    .round_num_o  (round_num),
    .round_done_o (round_done),
    .game_over_o  (game_over),
    .state_o      (state),
    .hud_time_o   (hud_time)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state plus cycles elapsed since entering it.
  int         m_state = 0;
  int         m_round = 0;
  int         m_elapsed = 0;
  logic       m_start_prev = 1'b1;
  logic       m_done = 1'b0;
  logic [7:0] m_hud = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_step();
    int  nstate;
    logic edge_seen;
    if (Reset) begin
      m_state = 0; m_round = 0; m_elapsed = 0; m_start_prev = 1'b1;
      m_done = 1'b0; m_hud = 8'h00;
    end else begin
      edge_seen = start & ~m_start_prev;
      nstate = m_state;
      m_done = 1'b0;
      if (abort && m_state != 0) begin
        nstate = 0; m_round = 0;
      end else begin
        case (m_state)
          0: if (edge_seen) begin nstate = 1; m_round = 1; end
          1: if (m_elapsed + 1 == RDY * HZ) nstate = 2;
          2: if (time_up) begin nstate = 3; m_done = 1'b1; end
          3: if (m_elapsed + 1 == ENDS * HZ) begin
               if (m_round == NR) nstate = 4;
               else begin nstate = 1; m_round = m_round + 1; end
             end
          4: if (edge_seen) begin nstate = 1; m_round = 1; end
          default: nstate = 0;
        endcase
      end
      m_elapsed = (nstate != m_state) ? 0 : m_elapsed + 1;
      m_start_prev = start;
      m_hud = (nstate == 2 || nstate == 3) ? time_left : 8'h00;
      m_state = nstate;
    end
  endtask

  task tick_clk();
    logic [22:0] exp_v, act_v;
    int          exp_ready;
    model_step();
    @(posedge Clk);
    #1;
    exp_ready = (m_state == 1) ? RDY - m_elapsed / HZ : 0;
    exp_v = {3'(m_state), (m_state != 2), (m_state == 2), 4'(exp_ready), 4'(m_round),
             m_done, (m_state == 4), m_hud};
    act_v = {state, timer_reset, playing, ready_count, round_num, round_done, game_over,
             hud_time};
    check("model", 32'(act_v), 32'(exp_v));
  endtask

  task wait_state(input logic [2:0] target, input int budget);
    int k;
    k = 0;
    while (state !== target && k < budget) begin
      tick_clk();
      k++;
    end
    check("wait_state", 32'(state), 32'(target));
  endtask

  typedef struct {
    int         n;
    logic       rst, st, ab, tu;
    logic [7:0] tl;
    logic [2:0] e_state;
    logic       e_tr, e_play, e_done, e_go;
    logic [3:0] e_ready, e_round;
    logic [7:0] e_hud;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2,  1, 1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 0, 4'd0, 4'd0, 8'h00};
    vecs[1]  = '{10, 0, 1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 0, 4'd0, 4'd0, 8'h00};
    vecs[2]  = '{1,  0, 0, 0, 0, 8'h00, 3'd0, 1, 0, 0, 0, 4'd0, 4'd0, 8'h00};
    vecs[3]  = '{1,  0, 1, 0, 0, 8'h00, 3'd1, 1, 0, 0, 0, 4'd3, 4'd1, 8'h00};
    vecs[4]  = '{3,  0, 1, 0, 0, 8'h00, 3'd1, 1, 0, 0, 0, 4'd3, 4'd1, 8'h00};
    vecs[5]  = '{1,  0, 1, 0, 0, 8'h00, 3'd1, 1, 0, 0, 0, 4'd2, 4'd1, 8'h00};
    vecs[6]  = '{4,  0, 0, 0, 0, 8'h00, 3'd1, 1, 0, 0, 0, 4'd1, 4'd1, 8'h00};
    vecs[7]  = '{3,  0, 1, 0, 0, 8'h00, 3'd1, 1, 0, 0, 0, 4'd1, 4'd1, 8'h00};
    vecs[8]  = '{1,  0, 1, 0, 0, 8'h59, 3'd2, 0, 1, 0, 0, 4'd0, 4'd1, 8'h59};
    vecs[9]  = '{5,  0, 1, 0, 0, 8'h37, 3'd2, 0, 1, 0, 0, 4'd0, 4'd1, 8'h37};
    vecs[10] = '{1,  0, 1, 0, 1, 8'h42, 3'd3, 1, 0, 1, 0, 4'd0, 4'd1, 8'h42};
    vecs[11] = '{1,  0, 1, 0, 0, 8'h41, 3'd3, 1, 0, 0, 0, 4'd0, 4'd1, 8'h41};
    vecs[12] = '{6,  0, 1, 0, 0, 8'h40, 3'd3, 1, 0, 0, 0, 4'd0, 4'd1, 8'h40};
    vecs[13] = '{1,  0, 1, 0, 0, 8'h40, 3'd1, 1, 0, 0, 0, 4'd3, 4'd2, 8'h00};

    for (int i = 0; i < 14; i++) begin
      Reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab;
      time_up = vecs[i].tu; time_left = vecs[i].tl;
      for (int c = 0; c < vecs[i].n; c++) tick_clk();
      check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d.timer_reset", i), 32'(timer_reset), 32'(vecs[i].e_tr));
      check($sformatf("vec%0d.playing", i), 32'(playing), 32'(vecs[i].e_play));
      check($sformatf("vec%0d.round_done", i), 32'(round_done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d.game_over", i), 32'(game_over), 32'(vecs[i].e_go));
      check($sformatf("vec%0d.ready_count", i), 32'(ready_count), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d.round_num", i), 32'(round_num), 32'(vecs[i].e_round));
      check($sformatf("vec%0d.hud_time", i), 32'(hud_time), 32'(vecs[i].e_hud));
    end
    time_left = 8'h00;

    // Finish rounds 2 and 3, land in OVER, then restart.
    for (int r = 2; r <= NR; r++) begin
      wait_state(3'd2, 40);
      time_up = 1'b1;
      tick_clk();
      time_up = 1'b0;
      check("round_done_pulse", 32'(round_done), 32'd1);
    end
    repeat (8) tick_clk();
    check("over.state", 32'(state), 32'd4);
    check("over.game_over", 32'(game_over), 32'd1);
    check("over.round_num", 32'(round_num), 32'd3);
    start = 1'b0; tick_clk();
    check("over.hold", 32'(state), 32'd4);
    start = 1'b1; tick_clk();
    check("restart.state", 32'(state), 32'd1);
    check("restart.round_num", 32'(round_num), 32'd1);
    check("restart.game_over", 32'(game_over), 32'd0);

    // abort beats time_up in the same PLAY cycle.
    wait_state(3'd2, 40);
    abort = 1'b1; time_up = 1'b1;
    tick_clk();
    abort = 1'b0; time_up = 1'b0;
    check("abort.state", 32'(state), 32'd0);
    check("abort.round_done", 32'(round_done), 32'd0);
    check("abort.round_num", 32'(round_num), 32'd0);
    check("abort.timer_reset", 32'(timer_reset), 32'd1);
    tick_clk();
    check("abort.round_done_after", 32'(round_done), 32'd0);

    // Reset in the middle of READY.
    start = 1'b0; tick_clk();
    start = 1'b1; tick_clk();
    repeat (4) tick_clk();
    check("midready.ready_count", 32'(ready_count), 32'd2);
    repeat (2) tick_clk();
    Reset = 1'b1; tick_clk();
    check("rst.state", 32'(state), 32'd0);
    check("rst.ready_count", 32'(ready_count), 32'd0);
    check("rst.round_num", 32'(round_num), 32'd0);
    check("rst.timer_reset", 32'(timer_reset), 32'd1);
    Reset = 1'b0; start = 1'b0; tick_clk();
    start = 1'b1; tick_clk();
    repeat (3) tick_clk();
    check("rst.prescaler_ready3", 32'(ready_count), 32'd3);
    tick_clk();
    check("rst.prescaler_ready2", 32'(ready_count), 32'd2);

    // Randomized traffic, checked each cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      Reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0) ? ~start : start;
      abort     = ($urandom_range(0, 79) == 0);
      time_up   = ($urandom_range(0, 7) == 0);
      time_left = 8'($urandom);
      tick_clk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
